// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - match sequencer: menu, countdown, gameplay, game over
//
// Purpose:
//   Top-level match sequencer. Walks MENU -> COUNTDOWN -> GAMEPLAY -> GAME_OVER,
//   publishes the state code for the mixer and overlay, the countdown digit and
//   the winner code, and issues one-cycle pulses to the player logic. All time
//   is measured in frame_tick pulses, so durations are in frames and seconds.
//
// Parameters:
//   FRAME_TICKS_PER_SEC  frame_tick pulses per second (>= 2)
//   COUNTDOWN_START      first digit shown in COUNTDOWN (1..15)
//   GAME_OVER_HOLD_SEC   seconds GAME_OVER lasts before returning to MENU (>= 1)
//
// Ports:
//   clk                 in   1  system (pixel) clock
//   rst_n               in   1  asynchronous active-low reset
//   frame_tick          in   1  one-cycle pulse per video frame
//   start_btn           in   1  start button level (synchronized, debounced)
//   p1_defeated         in   1  high while player 1 health is zero
//   p2_defeated         in   1  high while player 2 health is zero
//   current_game_state  out  3  000 MENU, 001 COUNTDOWN, 010 GAMEPLAY, 011 GAME_OVER
//   countdown_digit     out  4  overlay digit, 0 outside COUNTDOWN
//   winner              out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw
//   reset_players       out  1  one-cycle pulse when a match is started
//   gameplay_start      out  1  one-cycle pulse on entry to GAMEPLAY

module game_state_controller #(
  parameter int FRAME_TICKS_PER_SEC = 60,
  parameter int COUNTDOWN_START     = 3,
  parameter int GAME_OVER_HOLD_SEC  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       p1_defeated,
  input  logic       p2_defeated,
  output logic [2:0] current_game_state,
  output logic [3:0] countdown_digit,
  output logic [1:0] winner,
  output logic       reset_players,
  output logic       gameplay_start
);

  localparam int TICK_W = (FRAME_TICKS_PER_SEC > 2) ? $clog2(FRAME_TICKS_PER_SEC) : 1;
  localparam int HOLD_W = (GAME_OVER_HOLD_SEC > 1) ? $clog2(GAME_OVER_HOLD_SEC + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(FRAME_TICKS_PER_SEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(GAME_OVER_HOLD_SEC - 1);
  localparam logic [3:0]        DIGIT_START = 4'(COUNTDOWN_START);

  typedef enum logic [2:0] {
    ST_MENU      = 3'b000,
    ST_COUNTDOWN = 3'b001,
    ST_GAMEPLAY  = 3'b010,
    ST_GAME_OVER = 3'b011
  } state_e;

  // The state register is kept as raw bits so that the unused 1xx codes are
  // representable and the default branch below can steer them back to MENU.
  logic [2:0]        state_q;
  state_e            cur_state;
  state_e            state_d;

  logic [3:0]        digit_q, digit_d;
  logic [1:0]        winner_q, winner_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              start_prev_q;
  logic              reset_players_q, reset_players_d;
  logic              gameplay_start_q, gameplay_start_d;

  logic              start_edge;
  logic              second_elapsed;

  assign cur_state      = state_e'(state_q);

  // start_prev resets to 1 so a button held through reset is not an edge.
  assign start_edge     = start_btn & ~start_prev_q;
  assign second_elapsed = frame_tick & (tick_q == TICK_LAST);

  always_comb begin
    state_d          = cur_state;
    digit_d          = digit_q;
    winner_d         = winner_q;
    tick_d           = tick_q;
    hold_d           = hold_q;
    reset_players_d  = 1'b0;
    gameplay_start_d = 1'b0;

    case (cur_state)
      ST_MENU: begin
        if (start_edge) begin
          state_d         = ST_COUNTDOWN;
          digit_d         = DIGIT_START;
          tick_d          = '0;
          hold_d          = '0;
          winner_d        = 2'b00;
          reset_players_d = 1'b1;
        end
      end

      ST_COUNTDOWN: begin
        if (frame_tick) begin
          tick_d = second_elapsed ? '0 : tick_q + 1'b1;
        end
        if (second_elapsed) begin
          if (digit_q > 4'd1) begin
            digit_d = digit_q - 4'd1;
          end else begin
            state_d          = ST_GAMEPLAY;
            digit_d          = 4'd0;
            gameplay_start_d = 1'b1;
          end
        end
      end

      ST_GAMEPLAY: begin
        if (p1_defeated || p2_defeated) begin
          state_d  = ST_GAME_OVER;
          tick_d   = '0;
          hold_d   = '0;
          // Bit 1 set means P2 wins (P1 down), bit 0 set means P1 wins;
          // both defeated in the same cycle yields the draw code 11.
          winner_d = {p1_defeated, p2_defeated};
        end
      end

      ST_GAME_OVER: begin
        if (frame_tick) begin
          tick_d = second_elapsed ? '0 : tick_q + 1'b1;
        end
        // A rematch request takes priority over the hold expiring.
        if (start_edge) begin
          state_d         = ST_COUNTDOWN;
          digit_d         = DIGIT_START;
          tick_d          = '0;
          hold_d          = '0;
          winner_d        = 2'b00;
          reset_players_d = 1'b1;
        end else if (second_elapsed) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_MENU;
            hold_d  = '0;
          end else begin
            hold_d  = hold_q + 1'b1;
          end
        end
      end

      default: begin
        state_d  = ST_MENU;
        digit_d  = 4'd0;
        winner_d = 2'b00;
        tick_d   = '0;
        hold_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_MENU;
      digit_q          <= 4'd0;
      winner_q         <= 2'b00;
      tick_q           <= '0;
      hold_q           <= '0;
      start_prev_q     <= 1'b1;
      reset_players_q  <= 1'b0;
      gameplay_start_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      digit_q          <= digit_d;
      winner_q         <= winner_d;
      tick_q           <= tick_d;
      hold_q           <= hold_d;
      start_prev_q     <= start_btn;
      reset_players_q  <= reset_players_d;
      gameplay_start_q <= gameplay_start_d;
    end
  end

  assign current_game_state = state_q;
  assign countdown_digit    = digit_q;
  assign winner             = winner_q;
  assign reset_players      = reset_players_q;
  assign gameplay_start     = gameplay_start_q;

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - scoreboard bench for game_state_controller
module tb_game_state_controller;

  localparam int FPS  = 4;
  localparam int CS   = 3;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       p1_defeated = 1'b0;
  logic       p2_defeated = 1'b0;
  logic [2:0] current_game_state;
  logic [3:0] countdown_digit;
  logic [1:0] winner;
  logic       reset_players;
  logic       gameplay_start;

  always #5 clk = ~clk;

  game_state_controller #(
    .FRAME_TICKS_PER_SEC(FPS),
    .COUNTDOWN_START    (CS),
    .GAME_OVER_HOLD_SEC (HOLD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_tick        (frame_tick),
    .start_btn         (start_btn),
    .p1_defeated       (p1_defeated),
    .p2_defeated       (p2_defeated),
    .current_game_state(current_game_state),
    .countdown_digit   (countdown_digit),
    .winner            (winner),
    .reset_players     (reset_players),
    .gameplay_start    (gameplay_start)
  );

  // {state, digit, winner, reset_players, gameplay_start}
  logic [10:0] obs;
  assign obs = {current_game_state, countdown_digit, winner, reset_players, gameplay_start};

  typedef struct {
    string       name;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [10:0] pack(input int s, input int d, input int w,
                                       input int rp, input int gs);
    return {s[2:0], d[3:0], w[1:0], rp[0], gs[0]};
  endfunction

  // Digit shown after n frame ticks since COUNTDOWN entry.
  function automatic int cd_digit(input int n);
    return (n >= CS * FPS) ? 0 : CS - n / FPS;
  endfunction

  function automatic int cd_state(input int n);
    return (n >= CS * FPS) ? 2 : 1;
  endfunction

  task automatic push(input string name, input logic [10:0] v);
    exp_t x;
    x.name = name;
    x.v    = v;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_btn = 1'b1; frame_tick = 1'b0;
    push("reset", pack(0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      frame_tick = (c % 10 == 9);
      push($sformatf("held_start c%0d", c), pack(0, 0, 0, 0, 0));
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    end
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    push("start_drop", pack(0, 0, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    start_btn = 1'b1;
    push("start_edge", pack(1, CS, 0, 1, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    push("start_pulse_end", pack(1, CS, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_countdown();
    for (int t = 1; t <= CS * FPS; t++) begin
      for (int c = 0; c < 10; c++) begin
        int n;
        n = (c == 9) ? t : t - 1;
        frame_tick = (c == 9);
        start_btn  = !(t == 2 && c == 3);   // edge at c==4 must be ignored
        push($sformatf("countdown t%0d c%0d", t, c),
             pack(cd_state(n), cd_digit(n), 0, 0, (c == 9 && t == CS * FPS) ? 1 : 0));
        step();
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
      end
    end
    frame_tick = 1'b0;
    push("gameplay_pulse_end", pack(2, 0, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_gameplay(input int d1, input int d2, input int w);
    for (int c = 0; c < 3; c++) begin
      start_btn = (c != 0);                 // edge at c==1 must be ignored
      push($sformatf("gameplay_hold c%0d", c), pack(2, 0, 0, 0, 0));
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    end
    p1_defeated = d1[0];
    p2_defeated = d2[0];
    push($sformatf("defeat p1=%0d p2=%0d", d1, d2), pack(3, 0, w, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    p1_defeated = 1'b0;
    p2_defeated = 1'b0;
  endtask

  // pt = tick number carrying a start edge (0 = none).
  task automatic test_game_over(input int pt, input int w);
    bit          done;
    logic [10:0] x;
    done      = 1'b0;
    start_btn = 1'b0;
    for (int t = 1; t <= HOLD * FPS && !done; t++) begin
      for (int c = 0; c < 10 && !done; c++) begin
        frame_tick = (c == 9);
        start_btn  = (c == 9 && t == pt);
        if (c == 9 && t == pt)              x = pack(1, CS, 0, 1, 0);
        else if (c == 9 && t == HOLD * FPS) x = pack(0, 0, w, 0, 0);
        else                                x = pack(3, 0, w, 0, 0);
        push($sformatf("game_over pt%0d t%0d c%0d", pt, t, c), x);
        step();
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
        if (c == 9 && (t == pt || t == HOLD * FPS)) done = 1'b1;
      end
    end
    frame_tick = 1'b0;
    push($sformatf("game_over_after pt%0d", pt), (pt != 0) ? pack(1, CS, 0, 0, 0) : pack(0, 0, w, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_menu_start(input int w);
    start_btn = 1'b0;
    for (int c = 0; c < 20; c++) begin
      frame_tick = (c % 10 == 9);
      push($sformatf("menu_idle c%0d", c), pack(0, 0, w, 0, 0));
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    end
    frame_tick = 1'b0;
    start_btn  = 1'b1;
    push("menu_start", pack(1, CS, 0, 1, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    push("menu_start_end", pack(1, CS, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_reset_mid();
    start_btn = 1'b1;
    for (int t = 1; t <= FPS; t++) begin
      for (int c = 0; c < 10; c++) begin
        int n;
        n = (c == 9) ? t : t - 1;
        frame_tick = (c == 9);
        push($sformatf("pre_reset t%0d c%0d", t, c), pack(1, cd_digit(n), 0, 0, 0));
        step();
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
      end
    end
    frame_tick = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    push("reset_mid_async", pack(0, 0, 0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      push($sformatf("post_reset c%0d", c), pack(0, 0, 0, 0, 0));
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    end
    start_btn = 1'b0;
    push("post_reset_drop", pack(0, 0, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    start_btn = 1'b1;
    push("post_reset_start", pack(1, CS, 0, 1, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_illegal();
    push("illegal_pre", pack(1, CS, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    force dut.state_q = 3'b101;
    #1;
    release dut.state_q;
    push("illegal_forced", pack(5, CS, 0, 0, 0));
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    push("illegal_recover", pack(0, 0, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
    push("illegal_stay_menu", pack(0, 0, 0, 0, 0));
    step();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_gameplay(0, 1, 1);
    test_game_over(0, 1);
    test_menu_start(1);
    test_countdown();
    test_gameplay(1, 1, 3);
    test_game_over(3, 3);
    test_countdown();
    test_gameplay(1, 0, 2);
    test_game_over(HOLD * FPS, 2);
    test_reset_mid();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
